// File: rtl/mor1kx_rf_spr_access.sv
// Debug SPR-bus responder for GPR access through the register file's spare ports.
// Writes wait for a stalled pipeline with no writeback; reads bypass a same-cycle writeback.
module mor1kx_rf_spr_access #(
    parameter int unsigned OPTION_RF_ADDR_WIDTH = 5,
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter logic [15:0] SPR_GPR_BASE         = 16'h0400,
    parameter logic [7:0]  WR_TIMEOUT           = 8'd15
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [15:0]                     spr_bus_addr_i,
    input  logic                            spr_bus_stb_i,
    input  logic                            spr_bus_we_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
    output logic                            spr_bus_ack_o,
    output logic                            spr_gpr_err_o,
    input  logic                            cpu_stall_i,
    input  logic                            wb_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] result_i,
    output logic                            rf_rden_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] rf_rdad_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] rf_rdda_i,
    output logic                            rf_wren_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] rf_wrad_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] rf_wrda_o
);

    localparam int unsigned AW = OPTION_RF_ADDR_WIDTH;
    localparam int unsigned DW = OPTION_OPERAND_WIDTH;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            hit;
    logic            grant;
    logic            bypass;
    logic            latch;
    logic            capture;
    logic            err_d;

    // Upper address bits select the GPR window; the low bits are the index.
    assign hit    = spr_bus_stb_i & (spr_bus_addr_i[15:AW] == SPR_GPR_BASE[15:AW]);
    assign grant  = cpu_stall_i & ~wb_rf_wb_i;
    assign bypass = wb_rf_wb_i & (wb_rfd_adr_i == rf_wrad_o);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= CW'(0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rf_rden_o = 1'b0;
        rf_rdad_o = spr_bus_addr_i[AW-1:0];
        rf_wren_o = 1'b0;
        latch     = 1'b0;
        capture   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    latch = 1'b1;
                    if (spr_bus_we_i) begin
                        state_d = WR_WAIT;
                        cnt_d   = CW'(0);
                    end else begin
                        rf_rden_o = 1'b1;
                        state_d   = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                capture = 1'b1;
                state_d = ACK;
            end
            WR_WAIT: begin
                if (grant) begin
                    rf_wren_o = 1'b1;
                    state_d   = ACK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    // Grant wins over timeout when both land in the same cycle.
                    if (cnt_d == WR_TIMEOUT) begin
                        state_d = ACK;
                        err_d   = 1'b1;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latched request doubles as the RF write address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wrad_o <= AW'(0);
            rf_wrda_o <= DW'(0);
        end else if (latch) begin
            rf_wrad_o <= spr_bus_addr_i[AW-1:0];
            rf_wrda_o <= spr_bus_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spr_bus_ack_o <= 1'b0;
            spr_gpr_err_o <= 1'b0;
            spr_bus_dat_o <= DW'(0);
        end else begin
            spr_bus_ack_o <= (state_d == ACK);
            spr_gpr_err_o <= err_d;
            if (capture)
                spr_bus_dat_o <= bypass ? result_i : rf_rdda_i;
        end
    end

endmodule

// File: tb/tb_mor1kx_rf_spr_access.sv
// Randomized bench for mor1kx_rf_spr_access against a transaction-level GPR model.
`timescale 1ns/1ps
module tb_mor1kx_rf_spr_access;

    localparam logic [15:0] BASE = 16'h0400;
    localparam int          TMO  = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] spr_bus_addr_i;
    logic        spr_bus_stb_i;
    logic        spr_bus_we_i;
    logic [31:0] spr_bus_dat_i;
    logic [31:0] spr_bus_dat_o;
    logic        spr_bus_ack_o;
    logic        spr_gpr_err_o;
    logic        cpu_stall_i;
    logic        wb_rf_wb_i;
    logic [4:0]  wb_rfd_adr_i;
    logic [31:0] result_i;
    logic        rf_rden_o;
    logic [4:0]  rf_rdad_o;
    logic [31:0] rf_rdda_i;
    logic        rf_wren_o;
    logic [4:0]  rf_wrad_o;
    logic [31:0] rf_wrda_o;

    logic [31:0] ram   [32];
    logic [31:0] model [32];
    logic [31:0] last_read;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ac;

    mor1kx_rf_spr_access dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spr_bus_addr_i (spr_bus_addr_i),
        .spr_bus_stb_i  (spr_bus_stb_i),
        .spr_bus_we_i   (spr_bus_we_i),
        .spr_bus_dat_i  (spr_bus_dat_i),
        .spr_bus_dat_o  (spr_bus_dat_o),
        .spr_bus_ack_o  (spr_bus_ack_o),
        .spr_gpr_err_o  (spr_gpr_err_o),
        .cpu_stall_i    (cpu_stall_i),
        .wb_rf_wb_i     (wb_rf_wb_i),
        .wb_rfd_adr_i   (wb_rfd_adr_i),
        .result_i       (result_i),
        .rf_rden_o      (rf_rden_o),
        .rf_rdad_o      (rf_rdad_o),
        .rf_rdda_i      (rf_rdda_i),
        .rf_wren_o      (rf_wren_o),
        .rf_wrad_o      (rf_wrad_o),
        .rf_wrda_o      (rf_wrda_o)
    );

    always #5 clk = ~clk;

    // Register file RAM: both write ports, registered read port.
    always @(posedge clk) begin
        if (rf_wren_o)  ram[rf_wrad_o]    <= rf_wrda_o;
        if (wb_rf_wb_i) ram[wb_rfd_adr_i] <= result_i;
        if (rf_rden_o)  rf_rdda_i         <= ram[rf_rdad_o];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        spr_bus_stb_i = 1'b0;
        spr_bus_we_i  = 1'b0;
        wb_rf_wb_i    = 1'b0;
    endtask

    // Pipeline writeback for the current cycle; model tracks it.
    task automatic pipe_wb(input logic [4:0] adr, input logic [31:0] val);
        wb_rf_wb_i   = 1'b1;
        wb_rfd_adr_i = adr;
        result_i     = val;
        model[adr]   = val;
    endtask

    // mode: 0 no writeback in RD_WAIT, 1 same GPR, 2 other GPR, 3 random
    task automatic rd_txn(input logic [4:0] idx, input int mode, input logic [31:0] val, input logic hold);
        logic [31:0] exp;
        logic [4:0]  oadr;
        step();
        quiet();
        spr_bus_stb_i  = 1'b1;
        spr_bus_addr_i = BASE + 16'(idx);
        cpu_stall_i    = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("rd_rden", 32'(rf_rden_o), 32'd1);
        check("rd_rdad", 32'(rf_rdad_o), 32'(idx));
        check("rd_wren0", 32'(rf_wren_o), 32'd0);
        step();
        spr_bus_stb_i = hold;
        exp = model[idx];
        oadr = idx + 5'd1;
        if (mode == 3) mode = int'($urandom_range(0, 2));
        if (mode == 1) begin
            exp = val;
            pipe_wb(idx, val);
        end else if (mode == 2) begin
            pipe_wb(oadr, val);
        end
        @(negedge clk);
        check("rd_noack", 32'(spr_bus_ack_o), 32'd0);
        step();
        wb_rf_wb_i = 1'b0;
        @(negedge clk);
        check("rd_ack", 32'(spr_bus_ack_o), 32'd1);
        check("rd_dat", spr_bus_dat_o, exp);
        check("rd_err", 32'(spr_gpr_err_o), 32'd0);
        last_read = exp;
        step();
        spr_bus_stb_i = 1'b0;
        @(negedge clk);
        check("rd_ack1", 32'(spr_bus_ack_o), 32'd0);
    endtask

    // stall_mode: 0 never stalled, 1 always stalled, 2 random; writeback forced for first blk cycles
    task automatic wr_txn(input logic [4:0] idx, input logic [31:0] data, input int blk,
                          input int stall_mode, input logic hold, output int ack_at);
        logic done, exp_err, g;
        done    = 1'b0;
        exp_err = 1'b0;
        ack_at  = -1;
        step();
        quiet();
        spr_bus_stb_i  = 1'b1;
        spr_bus_we_i   = 1'b1;
        spr_bus_addr_i = BASE + 16'(idx);
        spr_bus_dat_i  = data;
        @(negedge clk);
        check("wr_t0_wren", 32'(rf_wren_o), 32'd0);
        for (int k = 1; k <= TMO + 1; k++) begin
            step();
            spr_bus_stb_i = hold;
            wb_rf_wb_i    = 1'b0;
            if (done) begin
                @(negedge clk);
                check("wr_ack", 32'(spr_bus_ack_o), 32'd1);
                check("wr_err", 32'(spr_gpr_err_o), 32'(exp_err));
                check("wr_dat_hold", spr_bus_dat_o, last_read);
                ack_at = k;
                break;
            end
            cpu_stall_i = (stall_mode == 1) ? 1'b1 :
                          (stall_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (k <= blk || (stall_mode == 2 && $urandom_range(0, 1) == 1))
                pipe_wb(5'($urandom), $urandom);
            g = cpu_stall_i & ~wb_rf_wb_i;
            @(negedge clk);
            check("wr_wren", 32'(rf_wren_o), 32'(g));
            check("wr_noack", 32'(spr_bus_ack_o), 32'd0);
            if (g) begin
                check("wr_wrad", 32'(rf_wrad_o), 32'(idx));
                check("wr_wrda", rf_wrda_o, data);
                model[idx] = data;
                done = 1'b1;
            end else if (k == TMO) begin
                exp_err = 1'b1;
                done    = 1'b1;
            end
        end
        step();
        quiet();
        @(negedge clk);
        check("wr_ack1", 32'(spr_bus_ack_o), 32'd0);
    endtask

    // Drive a non-hit request and confirm nothing responds.
    task automatic nohit(input logic [15:0] addr, input logic we);
        step();
        quiet();
        cpu_stall_i    = 1'b1;
        spr_bus_stb_i  = 1'b1;
        spr_bus_we_i   = we;
        spr_bus_addr_i = addr;
        spr_bus_dat_i  = $urandom;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("nh_rden", 32'(rf_rden_o), 32'd0);
            check("nh_wren", 32'(rf_wren_o), 32'd0);
            check("nh_ack", 32'(spr_bus_ack_o), 32'd0);
            step();
        end
        quiet();
    endtask

    initial begin
        rst_n          = 1'b0;
        spr_bus_addr_i = 16'h0;
        spr_bus_dat_i  = 32'h0;
        cpu_stall_i    = 1'b0;
        wb_rfd_adr_i   = 5'd0;
        result_i       = 32'h0;
        quiet();
        last_read = 32'h0;
        @(negedge clk);
        check("rst_ack", 32'(spr_bus_ack_o), 32'd0);
        check("rst_err", 32'(spr_gpr_err_o), 32'd0);
        check("rst_dat", spr_bus_dat_o, 32'h0);
        check("rst_wrad", 32'(rf_wrad_o), 32'd0);
        check("rst_wrda", rf_wrda_o, 32'h0);
        step();
        rst_n = 1'b1;

        // Preload every GPR through the pipeline writeback port.
        for (int i = 0; i < 32; i++) begin
            step();
            pipe_wb(5'(i), (i == 7) ? 32'h12345678 : $urandom);
        end
        step();
        quiet();

        wr_txn(5'd3, 32'hDEADBEEF, 0, 1, 1'b1, ac);
        check("wr_latency", 32'(ac), 32'd2);
        rd_txn(5'd7, 0, 32'h0, 1'b1);
        check("rd_gpr7", spr_bus_dat_o, 32'h12345678);
        rd_txn(5'd7, 1, 32'hCAFEF00D, 1'b0);
        check("rd_bypass", spr_bus_dat_o, 32'hCAFEF00D);
        rd_txn(5'd7, 2, 32'h0BADF00D, 1'b1);
        check("rd_nobypass", spr_bus_dat_o, 32'hCAFEF00D);
        wr_txn(5'd9, 32'h5A5A1234, 4, 1, 1'b1, ac);
        check("wr_blocked_latency", 32'(ac), 32'd6);
        wr_txn(5'd10, 32'h11112222, 0, 0, 1'b0, ac);
        check("wr_timeout_latency", 32'(ac), 32'(TMO + 1));
        rd_txn(5'd10, 0, 32'h0, 1'b0);

        // Reset while a write is waiting for the pipeline.
        step();
        quiet();
        cpu_stall_i    = 1'b0;
        spr_bus_stb_i  = 1'b1;
        spr_bus_we_i   = 1'b1;
        spr_bus_addr_i = BASE + 16'd12;
        spr_bus_dat_i  = 32'hFFFF0000;
        for (int k = 0; k < 3; k++) begin
            step();
            quiet();
        end
        rst_n = 1'b0;
        #1;
        check("mrst_ack", 32'(spr_bus_ack_o), 32'd0);
        check("mrst_err", 32'(spr_gpr_err_o), 32'd0);
        check("mrst_dat", spr_bus_dat_o, 32'h0);
        check("mrst_wrad", 32'(rf_wrad_o), 32'd0);
        check("mrst_wrda", rf_wrda_o, 32'h0);
        last_read = 32'h0;
        step();
        rst_n       = 1'b1;
        cpu_stall_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_wren", 32'(rf_wren_o), 32'd0);
            check("post_rst_ack", 32'(spr_bus_ack_o), 32'd0);
            step();
        end
        nohit(16'h0300, 1'b0);
        nohit(16'h0300, 1'b1);
        nohit(BASE + 16'd32, 1'b1);
        nohit(BASE + 16'd32, 1'b0);

        for (int t = 0; t < 60; t++) begin
            logic [4:0] idx;
            idx = 5'($urandom);
            if ($urandom_range(0, 1) == 1)
                rd_txn(idx, 3, $urandom, 1'($urandom_range(0, 1)));
            else
                wr_txn(idx, $urandom, int'($urandom_range(0, 3)),
                       ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 2)),
                       1'($urandom_range(0, 1)), ac);
        end

        for (int i = 0; i < 32; i++)
            rd_txn(5'(i), 0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
